// File: rtl/pattern_insert.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// pattern_insert
//
// Builds a continuous, unaligned, MSB-first bit stream for one frame:
//   [offset FILL bits][PAT][len payload words][optional ~PAT trailer][FILL pad]
// and emits it as WIDTH-bit words qualified by data_ena. Bit WIDTH-1 of each
// output word is the earliest bit in the stream.
//
// Optional feature: define PATTERN_INSERT_TRAILER_EN to append ~PAT after the
// last payload word, before the final padding. Ports are identical either way.
//
// Ports:
//   clk, nrst   clock, asynchronous active-low reset
//   start       single-cycle frame request (ignored while busy)
//   offset      FILL bits sent before PAT, latched on start
//   len         payload word count, latched on start (0 is legal)
//   pl_data     payload word, MSB first
//   pl_valid    payload word available
//   pl_ready    payload word accepted when pl_valid && pl_ready
//   data        output word
//   data_ena    output word valid
//   busy        frame in progress, from start through the done cycle
//   done        one-cycle pulse with the last word of the frame
//   dbg_state   current FSM state (IDLE=0, LOAD=1, PAYLOAD=2, FLUSH=3)
//
// Handshake: a payload word transfers on a rising clk edge where pl_valid and
// pl_ready are both 1. pl_ready is registered and only ever 1 in PAYLOAD with
// words still owed; pl_valid may be raised or dropped at any time.
// -----------------------------------------------------------------------------
module pattern_insert #(
  parameter int                   WIDTH     = 16,
  parameter int                   PAT_WIDTH = 5,
  parameter logic [PAT_WIDTH-1:0] PAT       = '1,
  parameter int                   LEN_W     = 8,
  parameter logic                 FILL      = 1'b0
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     start,
  input  logic [$clog2(WIDTH)-1:0] offset,
  input  logic [LEN_W-1:0]         len,
  input  logic [WIDTH-1:0]         pl_data,
  input  logic                     pl_valid,
  output logic                     pl_ready,
  output logic [WIDTH-1:0]         data,
  output logic                     data_ena,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               dbg_state
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(2 * WIDTH + 1);
  localparam int OW = $clog2(WIDTH);

  localparam logic [CW-1:0] CNT_WORD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_PAT  = CW'(PAT_WIDTH);

  // PAT and its complement left-justified in an accumulator-wide field.
  localparam logic [AW-1:0] PAT_EXT = {PAT, {(AW - PAT_WIDTH){1'b0}}};
  localparam logic [AW-1:0] TRL_EXT = {~PAT, {(AW - PAT_WIDTH){1'b0}}};

`ifdef PATTERN_INSERT_TRAILER_EN
  localparam logic TRAILER = 1'b1;
`else
  localparam logic TRAILER = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      acc_q, acc_d;     // left-justified pending stream bits
  logic [CW-1:0]      cnt_q, cnt_d;     // number of valid bits in acc_q
  logic [OW-1:0]      off_q, off_d;
  logic [LEN_W-1:0]   left_q, left_d;   // payload words still to accept
  logic               trl_q, trl_d;     // trailer still to be appended
  logic [WIDTH-1:0]   data_q, data_d;
  logic               ena_q, ena_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [AW-1:0]      post_acc;         // acc after this cycle's emit
  logic [CW-1:0]      post_cnt;
  logic               emit;
  logic               take;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    off_d    = off_q;
    left_d   = left_q;
    trl_d    = trl_q;
    data_d   = data_q;
    ena_d    = 1'b0;
    done_d   = 1'b0;
    post_acc = acc_q;
    post_cnt = cnt_q;
    emit     = 1'b0;
    take     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // busy_q is still 1 during the done cycle, so a start there is dropped.
        if (start && !busy_q) begin
          off_d   = offset;
          left_d  = len;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        acc_d   = (PAT_EXT >> off_q) | (FILL ? ~({AW{1'b1}} >> off_q) : '0);
        cnt_d   = CW'(off_q) + CNT_PAT;
        trl_d   = TRAILER;
        state_d = ST_PAYLOAD;
      end

      ST_PAYLOAD: begin
        emit = (cnt_q >= CNT_WORD);
        if (emit) begin
          data_d   = acc_q[AW-1 -: WIDTH];
          ena_d    = 1'b1;
          post_acc = acc_q << WIDTH;
          post_cnt = cnt_q - CNT_WORD;
        end
        acc_d = post_acc;
        cnt_d = post_cnt;
        // post_cnt < WIDTH whenever we get here, so the append always fits.
        take = pl_valid && rdy_q;
        if (take) begin
          acc_d  = post_acc | ({pl_data, {WIDTH{1'b0}}} >> post_cnt);
          cnt_d  = post_cnt + CNT_WORD;
          left_d = left_q - LEN_W'(1);
        end
        if (left_d == '0) begin
          // If this emit drained everything, it is the frame's last word.
          if (cnt_d == '0 && !trl_q && emit) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        if (cnt_q >= CNT_WORD) begin
          data_d   = acc_q[AW-1 -: WIDTH];
          ena_d    = 1'b1;
          post_acc = acc_q << WIDTH;
          post_cnt = cnt_q - CNT_WORD;
        end else if (cnt_q != '0 && !trl_q) begin
          // Partial last word: bits below cnt are zero, so only FILL=1 needs OR.
          data_d   = acc_q[AW-1 -: WIDTH] | (FILL ? ({WIDTH{1'b1}} >> cnt_q) : '0);
          ena_d    = 1'b1;
          post_acc = '0;
          post_cnt = '0;
        end
        acc_d = post_acc;
        cnt_d = post_cnt;
        if (trl_q) begin
          acc_d = post_acc | (TRL_EXT >> post_cnt);
          cnt_d = post_cnt + CNT_PAT;
          trl_d = 1'b0;
        end
        if (!trl_q && cnt_d == '0) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    rdy_d  = (state_d == ST_PAYLOAD) && (left_d != '0);
    busy_d = (state_d != ST_IDLE) || done_d;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      left_q  <= '0;
      trl_q   <= 1'b0;
      data_q  <= '0;
      ena_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      left_q  <= left_d;
      trl_q   <= trl_d;
      data_q  <= data_d;
      ena_q   <= ena_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pl_ready  = rdy_q;
  assign data      = data_q;
  assign data_ena  = ena_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: doc/pattern_insert.md
Name: pattern_insert

Overview:
Transmit-side companion to the pattern detector. Builds a continuous, unaligned bit stream of optional fill bits, then the sync pattern PAT, then a caller-supplied number of payload words. It emits that stream as WIDTH-bit parallel words with a qualifying enable. It sits upstream of a parallel serial-style link (e.g. QSPI-like lanes) and doubles as a stimulus source for placing PAT at any bit position.

Parameters:
WIDTH, 16, output/payload word width in bits
PAT_WIDTH, 5, sync pattern width; legal range 1..WIDTH
PAT, '1 (PAT_WIDTH bits), sync pattern, sent MSB first
LEN_W, 8, width of payload length field
FILL, 1'b0, value of lead-in offset bits and tail padding bits

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
start  in  1  single-cycle frame request; ignored while busy=1
offset  in  $clog2(WIDTH)  number of FILL bits sent before PAT (0..WIDTH-1), latched on start
len  in  LEN_W  payload word count, latched on start; 0 is legal
pl_data  in  WIDTH  payload word, MSB sent first
pl_valid  in  1  payload word available
pl_ready  out  1  payload word accepted when pl_valid&&pl_ready
data  out  WIDTH  output word; bit WIDTH-1 is earliest in stream
data_ena  out  1  data word valid
busy  out  1  frame in progress (start..done inclusive)
done  out  1  one-cycle pulse with last word of frame

Behaviour:
- Bit order: the stream is MSB first. Within each output word, data[WIDTH-1] precedes data[0]. Consecutive words are contiguous in the stream.
- Storage: accumulator acc of 2*WIDTH bits, left-justified, plus bit count cnt (0..2*WIDTH).
- Reset (async, nrst=0): state=IDLE, acc=0, cnt=0, data=0, data_ena=0, pl_ready=0, busy=0, done=0. Reset mid-frame aborts the frame immediately; no partial words are emitted afterwards.
- IDLE: busy=0. On start=1, latch offset and len, then go to LOAD.
- LOAD (1 cycle): busy=1. acc <= {offset FILL bits, PAT, zeros}, cnt <= offset+PAT_WIDTH. Go to PAYLOAD.
- PAYLOAD:
  - When cnt>=WIDTH, emit the top WIDTH bits of acc: registered data and data_ena=1 next cycle. acc shifts left by WIDTH and cnt drops by WIDTH.
  - pl_ready=1 while words_left!=0. On accept, append pl_data immediately after the remaining valid bits, cnt += WIDTH, words_left--.
  - Emit and accept may occur in the same cycle.
  - If pl_valid=0 and cnt<WIDTH, no word is emitted that cycle (data_ena=0 bubble). data holds its last value.
  - When words_left==0, go to FLUSH.
- FLUSH:
  - While cnt>=WIDTH, emit full words.
  - If 0<cnt<WIDTH, pad to WIDTH with FILL bits and emit one final word.
  - The final word asserts done=1 in the same cycle as its data_ena, then go to IDLE.
  - If cnt==0 on entry, done pulses with the last previously emitted word; if none is pending, done pulses alone with data_ena=0.
- Throughput: with pl_valid held high, one output word per cycle in steady state.
- Latency: start at edge N gives the first data_ena no earlier than edge N+3.
- cnt never exceeds 2*WIDTH. This holds by construction because an accept only happens when the post-emit count is <=WIDTH.
- start asserted while busy=1 is ignored; it is not queued.
- pl_data is not consumed outside PAYLOAD (pl_ready=0).

Optional Feature:
Macro PATTERN_INSERT_TRAILER_EN.
- Defined: after the last payload word and before padding, append ~PAT (PAT_WIDTH bits, MSB first) as an end-of-frame marker. FLUSH then pads as usual.
- Undefined: no trailer; the stream ends with the payload, then padding.
- No ports change in either case.

Test Plan:
- WIDTH=8, PAT=5'b10011, offset=0, len=1, pl_data=8'hFF -> data 8'b10011111 then 8'b11111000, done on the second word, busy drops the next cycle.
- Same config, offset=3, len=0 -> single word 8'b00010011 with done=1. Connecting the detector downstream flags the pattern at bit position 0 of that word.
- WIDTH=8, PAT=5'b10011, offset=7, len=2, pl_data 8'hA5, 8'h3C, pl_valid held high -> 3 words: 8'b00000001, 8'b00111010, 8'b01010011. Then a padded word 8'b11000000 with done. No bubbles occur.
- Same as above but pl_valid low for 3 cycles mid-frame -> data_ena bubbles appear, the word contents are identical to the uninterrupted case, and pl_ready stays 1.
- Pulse nrst low while the second payload word is pending -> data_ena=0, busy=0, and pl_ready=0 within the reset assertion. A new start after release produces a clean frame.
- With PATTERN_INSERT_TRAILER_EN, test 1 config -> stream 10011 11111111 01100 plus 6 pad bits: 8'b10011111, 8'b11111011, 8'b00000000.
